// File: rtl/freq_pkg.sv
`default_nettype none
// ============================================================================
//  freq_pkg : shared constants for the frequency measure / divider family
//  Rev 1.0  : initial release
// ============================================================================
package freq_pkg;

    localparam int FREQ_WIDTH = 27;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

endpackage : freq_pkg
`default_nettype wire

// File: rtl/freq_measure_if.sv
`default_nettype none
// ============================================================================
//  freq_measure_if : input square wave plus measurement result bundle
//  Rev 1.0  : initial release
// ============================================================================
interface freq_measure_if
    import freq_pkg::*;
#(
    parameter int WIDTH = FREQ_WIDTH
) ();

    logic             sig_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             stalled;

    // master drives the wave and watches results; slave is the measuring block
    modport master (
        output sig_in,
        input  period, high_time, valid, locked, stalled
    );

    modport slave (
        input  sig_in,
        output period, high_time, valid, locked, stalled
    );

endinterface : freq_measure_if
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  sync_edge : multi-flop synchronizer with registered rise/fall detection
//  Rev 1.0  : initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_sig,
    output logic      o_lvl,
    output logic      o_rise,
    output logic      o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_lvl;

    assign w_lvl = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '0;
            r_lvl_d <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_lvl_d <= w_lvl;
            r_rise  <= w_lvl & ~r_lvl_d;
            r_fall  <= ~w_lvl & r_lvl_d;
        end
    end

    // lvl is taken after the edge register so it lines up with rise/fall
    assign o_lvl  = r_lvl_d;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule : sync_edge
`default_nettype wire

// File: rtl/freq_measure.sv
`default_nettype none
// ============================================================================
//  freq_measure : period / high-time monitor of a slow asynchronous input
//  Rev 1.0  : initial release
// ============================================================================
module freq_measure
    import freq_pkg::*;
#(
    parameter int WIDTH       = FREQ_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic     sysclk,
    input  wire logic     reset,
    freq_measure_if.slave bus
);

    localparam logic [WIDTH-1:0] C_FULL = '1;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic             w_lvl;
    logic             w_rise;
    logic             w_fall;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pcnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_hcap;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic             r_locked;
    logic             r_stalled;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (sysclk),
        .rst    (reset),
        .i_sig  (bus.sig_in),
        .o_lvl  (w_lvl),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // both counters saturate so a dead input can never alias to a short period
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_pcnt <= '0;
            r_hcnt <= '0;
            r_hcap <= '0;
        end else begin
            if (w_rise)
                r_pcnt <= C_ONE;
            else if (r_pcnt != C_FULL)
                r_pcnt <= r_pcnt + C_ONE;

            if (w_rise)
                r_hcnt <= C_ONE;
            else if (w_lvl && (r_hcnt != C_FULL))
                r_hcnt <= r_hcnt + C_ONE;

            if (w_fall)
                r_hcap <= r_hcnt;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise)
                        r_state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    // a rise on the saturating cycle still counts as a measurement
                    if (w_rise) begin
                        r_period <= r_pcnt;
                        r_high   <= r_hcap;
                        r_valid  <= 1'b1;
                        r_locked <= 1'b1;
                    end else if (r_pcnt == C_FULL) begin
                        r_state   <= ST_STALLED;
                        r_stalled <= 1'b1;
                        r_locked  <= 1'b0;
                    end
                end
                ST_STALLED: begin
                    if (w_rise) begin
                        r_state   <= ST_MEASURE;
                        r_stalled <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.period    = r_period;
    assign bus.high_time = r_high;
    assign bus.valid     = r_valid;
    assign bus.locked    = r_locked;
    assign bus.stalled   = r_stalled;

endmodule : freq_measure
`default_nettype wire
